// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, bit-period helper and frame geometry.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
// Used by uart_tx and uart_rx so both ends derive the bit period identically.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  // 8N1: start + 8 data + stop
  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 10;

  // Clock cycles per serial bit (integer division, truncating).
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO between producers and the serial shifter.
// Latency: push visible in count on the next edge; pop_dat registered, valid the cycle after pop.
// Backpressure: push is ignored while full, pop is ignored while empty.
// Ports: clk/rst_n; push/push_dat write side; pop/pop_dat read side; full/empty/count status.
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] pop_dat_q;
  logic             push_ok, pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign pop_dat = pop_dat_q;

  // Full-ness is judged on the current count, so a push while full is lost
  // even if a pop frees a slot on the same edge.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    count_d  = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + 1'b1;
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      pop_dat_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (pop_ok) begin
        pop_dat_q <= mem_q[rd_ptr_q];
      end
    end
  end

  // Storage is not reset; resetting the pointers discards the contents.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_dat;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a byte FIFO in front of the bit shifter.
// Latency: byte pushed into an empty idle FIFO at edge E starts its start bit after E+1.
// Backpressure: data_ready low while FIFO holds FIFO_DEPTH bytes; frames run back-to-back.
// Ports: clk/rst_n; data_in/data_valid/data_ready producer side; tx line, tx_busy, fifo_count.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    data_in,
  input  logic                          data_valid,
  output logic                          data_ready,
  output logic                          tx,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CPB = clks_per_bit(CLK_FREQ, BAUD);
  localparam int BW  = (CPB > 1) ? $clog2(CPB) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CPB - 1);

  logic        fifo_pop;
  logic [7:0]  fifo_dat;
  logic        fifo_full, fifo_empty;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (data_valid),
    .push_dat (data_in),
    .pop      (fifo_pop),
    .pop_dat  (fifo_dat),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign data_ready = !fifo_full;

  uart_state_e state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          load_q, load_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          baud_end;

  assign baud_end = (baud_q == BAUD_LAST);

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    fifo_pop = 1'b0;
    tx_d     = 1'b1;
    busy_d   = 1'b0;

    // FIFO read data lands one cycle after the pop; the shifter picks it up
    // then, which is still inside the start bit.
    if (load_q) begin
      shift_d = fifo_dat;
    end

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = ST_START;
          baud_d   = '0;
          bit_d    = '0;
        end
      end
      ST_START: begin
        if (baud_end) begin
          state_d = ST_DATA;
          baud_d  = '0;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (baud_end) begin
          baud_d = '0;
          bit_d  = bit_q + 1'b1;   // wraps 7 -> 0 on leaving DATA
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            shift_d = shift_d >> 1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (baud_end) begin
          baud_d = '0;
          if (!fifo_empty) begin
            // chain straight into the next start bit, no idle cycle
            fifo_pop = 1'b1;
            state_d  = ST_START;
            bit_d    = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs follow the next state so tx/tx_busy are registered yet aligned.
    case (state_d)
      ST_START: begin tx_d = 1'b0;       busy_d = 1'b1; end
      ST_DATA:  begin tx_d = shift_d[0]; busy_d = 1'b1; end
      ST_STOP:  begin tx_d = 1'b1;       busy_d = 1'b1; end
      default:  begin tx_d = 1'b1;       busy_d = 1'b0; end
    endcase

    load_d = fifo_pop;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      load_q  <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      load_q  <= load_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  assign tx      = tx_q;
  assign tx_busy = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx at 10 clocks per bit: a frame-time reference model predicts
// tx, tx_busy, fifo_count and data_ready every cycle under directed and random traffic.
module tb_uart_tx;

  localparam int CLK_FREQ = 1000000;
  localparam int BAUD     = 100000;
  localparam int DEPTH    = 16;
  localparam int C        = CLK_FREQ / BAUD;
  localparam int FRAME    = 10 * C;

  logic       clk;
  logic       rst_n;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready;
  logic       tx;
  logic       tx_busy;
  logic [$clog2(DEPTH):0] fifo_count;

  uart_tx #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .tx         (tx),
    .tx_busy    (tx_busy),
    .fifo_count (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: bytes waiting, the byte on the line, and the cycle
  // position inside the current frame (-1 when the line is idle).
  logic [7:0] mq[$];
  logic [7:0] mcur;
  int         mt;

  function automatic logic exp_tx();
    int b;
    if (mt < 0) return 1'b1;
    b = mt / C;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return mcur[b-1];
  endfunction

  task automatic model_step(input logic v, input logic [7:0] d);
    bit acc;
    acc = v && (mq.size() != DEPTH);
    if (mt < 0) begin
      if (mq.size() > 0) begin
        mcur = mq.pop_front();
        mt   = 0;
      end
    end else begin
      mt++;
      if (mt == FRAME) begin
        if (mq.size() > 0) begin
          mcur = mq.pop_front();
          mt   = 0;
        end else begin
          mt = -1;
        end
      end
    end
    if (acc) mq.push_back(d);
  endtask

  task automatic compare_all();
    check("tx",         int'(tx),         int'(exp_tx()));
    check("tx_busy",    int'(tx_busy),    (mt >= 0) ? 1 : 0);
    check("fifo_count", int'(fifo_count), mq.size());
    check("data_ready", int'(data_ready), (mq.size() != DEPTH) ? 1 : 0);
  endtask

  // One clock: drive inputs, compare on the falling edge, advance model on the rising edge.
  task automatic tick(input logic v, input logic [7:0] d);
    data_valid = v;
    data_in    = d;
    @(negedge clk);
    compare_all();
    @(posedge clk);
    model_step(v, d);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 8'h00);
  endtask

  task automatic reset_release();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    model_step(1'b0, 8'h00);
    #1;
  endtask

  initial begin
    int k;
    int guard;
    logic rdy;

    rst_n      = 1'b0;
    data_valid = 1'b0;
    data_in    = 8'h00;
    mt         = -1;
    mcur       = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx",    int'(tx), 1);
    check("rst_busy",  int'(tx_busy), 0);
    check("rst_count", int'(fifo_count), 0);
    check("rst_ready", int'(data_ready), 1);
    reset_release();

    // Single byte 0xA5
    tick(1'b1, 8'hA5);
    idle(FRAME + 10);

    // Back-to-back 0x55 then 0x00
    tick(1'b1, 8'h55);
    tick(1'b1, 8'h00);
    idle(2 * FRAME + 10);

    // Overflow: producer holds valid and advances on each accepted byte
    k = 0;
    for (int i = 0; i < 40; i++) begin
      rdy = data_ready;
      tick(1'b1, 8'(k));
      if (rdy) k++;
    end
    check("ovf_accepted", k, 17);
    check("ovf_count", int'(fifo_count), 16);
    check("ovf_ready", int'(data_ready), 0);
    idle(17 * FRAME + 20);

    // Push on the same edge as the STOP->START pop with one byte queued
    tick(1'b1, 8'h11);
    tick(1'b1, 8'h22);
    guard = 0;
    while (!(mt == FRAME - 1 && mq.size() == 1) && guard < 3 * FRAME) begin
      tick(1'b0, 8'h00);
      guard++;
    end
    check("same_edge_reached", (guard < 3 * FRAME) ? 1 : 0, 1);
    tick(1'b1, 8'h33);
    check("same_edge_count", int'(fifo_count), 1);
    idle(3 * FRAME + 10);

    // Reset in the middle of the data bits with 3 bytes queued
    for (int i = 0; i < 4; i++) tick(1'b1, 8'hC0 + 8'(i));
    guard = 0;
    while (mt < 3 * C && guard < 2 * FRAME) begin
      tick(1'b0, 8'h00);
      guard++;
    end
    check("mid_reached", (mt >= 3 * C && mt < 9 * C) ? 1 : 0, 1);
    check("mid_queued", int'(fifo_count), 3);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_tx",    int'(tx), 1);
    check("arst_busy",  int'(tx_busy), 0);
    check("arst_count", int'(fifo_count), 0);
    check("arst_ready", int'(data_ready), 1);
    mq.delete();
    mt = -1;
    repeat (2) @(posedge clk);
    reset_release();
    idle(1000);

    // Random sparse and bursty traffic
    for (int i = 0; i < 3000; i++) begin
      tick(($urandom_range(0, 29) == 0) || (i % 700 < 20 && $urandom_range(0, 1) == 1),
           8'($urandom));
    end
    guard = 0;
    while ((mt >= 0 || mq.size() > 0) && guard < (DEPTH + 2) * FRAME) begin
      tick(1'b0, 8'h00);
      guard++;
    end
    check("drain_done", (mt < 0 && mq.size() == 0) ? 1 : 0, 1);
    idle(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
